vr_udp_tx_arbiter: RTL and testbench
====================================

// Module: vr_udp_tx_arbiter
// PURPOSE
//  Shares one UDP TX interface (metadata bus + data bus) between NUM_REQ VR engines (prepare, commit, etc.).
//  Round-robin arbitration; each grant covers one message: one meta beat, then data beats through data_last.
//  Sits between the engine reply outputs and the UDP TX formatter.
// PARAMETERS
//  NUM_REQ     4    number of requesting engines (2..8)
//  META_W      96   width of one UDP metadata word
//  DATA_W      512  data bus width
//  PAD_W       6    padbytes field width (log2(DATA_W/8))
//  WDOG_CYCLES 1024 watchdog limit in cycles (used only with VR_TX_ARB_WDOG_EN)
// PORTS
//  clk               in   1              clock
//  rst_n             in   1              asynchronous, active-low reset
//  req_meta_val      in   NUM_REQ        per-engine metadata valid
//  req_meta          in   NUM_REQ*META_W per-engine metadata; slice i = [i*META_W +: META_W]
//  req_meta_rdy      out  NUM_REQ        per-engine metadata ready
//  req_data_val      in   NUM_REQ        per-engine data valid
//  req_data          in   NUM_REQ*DATA_W per-engine data
//  req_data_last     in   NUM_REQ        per-engine last beat
//  req_data_padbytes in   NUM_REQ*PAD_W  per-engine pad bytes on the last beat
//  req_data_rdy      out  NUM_REQ        per-engine data ready
//  tx_meta_val/tx_meta     out 1/META_W  metadata to UDP TX
//  tx_meta_rdy       in   1              metadata ready from UDP TX
//  tx_data_val/tx_data     out 1/DATA_W  data to UDP TX
//  tx_data_last/tx_data_padbytes out 1/PAD_W  last beat and pad bytes
//  tx_data_rdy       in   1              data ready from UDP TX
//  grant_id          out  $clog2(NUM_REQ) current grant holder
//  arb_busy          out  1              high in any state other than IDLE
//  wdog_err          out  1              sticky watchdog error (tied 0 when the macro is undefined)
// BEHAVIOUR
//  - Reset (async assert, sync release): state = IDLE, rr_ptr = 0, grant_id = 0, wdog_err = 0.
//    All val/rdy outputs are 0. tx_meta, tx_data and padbytes are driven 0 in IDLE.
//  - States:
//    IDLE: if any req_meta_val is set, select the first set bit at or after rr_ptr (wrapping),
//          register it as grant_id, and go to META. Selection takes 1 cycle; no rdy is asserted in IDLE.
//    META: tx_meta_val = req_meta_val[g] and tx_meta = slice g. req_meta_rdy[g] = tx_meta_rdy.
//          On a val&rdy handshake, go to DATA.
//    DATA: tx_data* mirror slice g. req_data_rdy[g] = tx_data_rdy.
//          On val&rdy&last: go to IDLE and set rr_ptr = (g+1) mod NUM_REQ.
//  - Forwarding in META and DATA is combinational (zero latency, no buffering).
//    Non-granted rdys are always 0. Data valid from an engine is ignored unless that engine holds the grant.
//  - A message with no data (meta only) is not supported. Every grant requires at least one data beat with last.
//  - Minimum cost per message: 1 arbitration cycle + 1 meta cycle + N data beats.
//    Back-to-back from one engine: IDLE occupies 1 cycle between messages.
//  - Simultaneous requests: the round-robin order guarantees each waiting engine a grant within NUM_REQ messages.
//  - Requester drops req_meta_val in META: the arbiter stays in META and the grant is held (protocol requires valid to be held).
//  - Reset mid-message: the message is abandoned. The engines and the UDP TX block are reset by the same rst_n.
// CONFIGURATION
//  VR_TX_ARB_WDOG_EN defined:
//  - In DATA, a counter increments each cycle that req_data_val[g] is 0 and clears on any data handshake.
//  - When the count reaches WDOG_CYCLES, the arbiter drives tx_data_val=1, tx_data_last=1, padbytes=0 for one
//    beat to close the frame. It then sets wdog_err (sticky until reset), advances rr_ptr, and goes to IDLE.
//  - If tx_data_rdy is low, the closing beat is held until accepted.
//  VR_TX_ARB_WDOG_EN undefined: no counter; wdog_err = 0; the arbiter waits in DATA indefinitely.
// STRUCTURE
//  - Package vr_tx_arb_pkg: arbiter state enum (IDLE, META, DATA, WDOG_CLOSE) and the GRANT_W localparam helper.
//  - Sub-module vr_rr_pick: a combinational rotate/priority-encode/unrotate that takes (req vector, rr_ptr)
//    and returns (grant index, any_req).
//  - Top level: FSM, grant register, output muxes, optional watchdog.
// TESTING
//  1. Single engine 2: meta + 3 data beats (last on beat 3, padbytes=5).
//     -> grant_id=2 one cycle after meta_val; tx sees meta, then 3 beats with padbytes=5; rr_ptr=3.
//  2. All 4 engines request from reset, each sends 1 beat.
//     -> grant order 0,1,2,3; each req_meta_rdy pulses once; no overlap.
//  3. Backpressure: tx_meta_rdy low for 5 cycles, then tx_data_rdy toggling.
//     -> no beat is lost or duplicated; the non-granted engines' rdys stay 0 throughout.
//  4. Engines 1 and 3 pending after a grant to 1 (rr_ptr=2).
//     -> 3 is granted before 1's second message.
//  5. Assert rst_n=0 mid-DATA.
//     -> outputs drop to 0 asynchronously; after release, IDLE with rr_ptr=0.
//  6. (WDOG_EN, WDOG_CYCLES=16) Engine 0 stalls after 1 beat.
//     -> after 16 idle cycles a closing last beat is sent, wdog_err=1, and engine 1's pending request is granted next.

Source files
------------

// File: rtl/vr_tx_arb_pkg.sv
// Shared types for the UDP TX arbiter: FSM state encoding and grant-width helper.
package vr_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      META       = 2'd1,
      DATA       = 2'd2,
      WDOG_CLOSE = 2'd3
   } arb_state_t;

   // Width of a grant index; never below one bit so a 2-engine build still has a register.
   function automatic int grant_w(input int num_req);
      return (num_req > 2) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/vr_rr_pick.sv
// Round-robin picker: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back. Purely combinational.
module vr_rr_pick
   import vr_tx_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GRANT_W = grant_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GRANT_W-1:0] rr_ptr,
   output logic [GRANT_W-1:0] grant,
   output logic               any_req
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [GRANT_W-1:0]   off;
   logic [GRANT_W:0]     sum;

   // Rotate, priority-encode from the pointer position, unrotate modulo NUM_REQ.
   always_comb begin
      dbl = {req, req} >> rr_ptr;
      rot = dbl[NUM_REQ-1:0];
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = GRANT_W'(i);
      end
      sum = {1'b0, off} + {1'b0, rr_ptr};
      if (sum >= (GRANT_W+1)'(NUM_REQ)) sum = sum - (GRANT_W+1)'(NUM_REQ);
      grant   = sum[GRANT_W-1:0];
      any_req = |req;
   end

endmodule

// File: rtl/vr_udp_tx_arbiter.sv
// Round-robin sharing of one UDP TX meta/data interface between NUM_REQ engines.
// Each grant carries one meta beat followed by data beats up to data_last.
// Optional frame-closing watchdog: define VR_TX_ARB_WDOG_EN.
module vr_udp_tx_arbiter
   import vr_tx_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int META_W      = 96,
   parameter int DATA_W      = 512,
   parameter int PAD_W       = 6,
   parameter int WDOG_CYCLES = 1024,
   localparam int GRANT_W    = grant_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_meta_val,
   input  logic [NUM_REQ*META_W-1:0] req_meta,
   output logic [NUM_REQ-1:0]        req_meta_rdy,
   input  logic [NUM_REQ-1:0]        req_data_val,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_data_last,
   input  logic [NUM_REQ*PAD_W-1:0]  req_data_padbytes,
   output logic [NUM_REQ-1:0]        req_data_rdy,
   output logic                      tx_meta_val,
   output logic [META_W-1:0]         tx_meta,
   input  logic                      tx_meta_rdy,
   output logic                      tx_data_val,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_data_last,
   output logic [PAD_W-1:0]          tx_data_padbytes,
   input  logic                      tx_data_rdy,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      arb_busy,
   output logic                      wdog_err
);

   arb_state_t         state_reg;
   logic [GRANT_W-1:0] grant_reg;
   logic [GRANT_W-1:0] rr_ptr_reg;
   logic [GRANT_W-1:0] pick;
   logic               any_req;
   logic               data_hs;
   logic [GRANT_W-1:0] ptr_next;

   vr_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GRANT_W (GRANT_W)
   ) u_pick (
      .req     (req_meta_val),
      .rr_ptr  (rr_ptr_reg),
      .grant   (pick),
      .any_req (any_req)
   );

   assign data_hs  = req_data_val[grant_reg] & tx_data_rdy;
   assign ptr_next = (grant_reg == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
   assign grant_id = grant_reg;
   assign arb_busy = (state_reg != IDLE);

`ifdef VR_TX_ARB_WDOG_EN
   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
   logic [CNT_W-1:0] wdog_cnt_reg;
   logic             wdog_err_reg;
   assign wdog_err = wdog_err_reg;
`else
   assign wdog_err = 1'b0;
`endif

   // Arbitration FSM: grant selection, message tracking, pointer advance, watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         grant_reg  <= '0;
         rr_ptr_reg <= '0;
`ifdef VR_TX_ARB_WDOG_EN
         wdog_cnt_reg <= '0;
         wdog_err_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  grant_reg <= pick;
                  state_reg <= META;
               end
`ifdef VR_TX_ARB_WDOG_EN
               wdog_cnt_reg <= '0;
`endif
            end
            META: begin
               if (req_meta_val[grant_reg] && tx_meta_rdy) state_reg <= DATA;
            end
            DATA: begin
               if (data_hs && req_data_last[grant_reg]) begin
                  state_reg  <= IDLE;
                  rr_ptr_reg <= ptr_next;
               end
`ifdef VR_TX_ARB_WDOG_EN
               // Count only cycles where the engine offers nothing; backpressure is not a stall.
               if (data_hs) begin
                  wdog_cnt_reg <= '0;
               end else if (!req_data_val[grant_reg]) begin
                  if (wdog_cnt_reg == CNT_W'(WDOG_CYCLES - 1)) begin
                     wdog_cnt_reg <= '0;
                     state_reg    <= WDOG_CLOSE;
                  end else begin
                     wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
                  end
               end
`endif
            end
            WDOG_CLOSE: begin
`ifdef VR_TX_ARB_WDOG_EN
               if (tx_data_rdy) begin
                  wdog_err_reg <= 1'b1;
                  rr_ptr_reg   <= ptr_next;
                  state_reg    <= IDLE;
               end
`else
               state_reg <= IDLE;
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Zero-latency forwarding of the granted engine's meta/data; everything else idles at 0.
   always_comb begin
      tx_meta_val      = 1'b0;
      tx_meta          = '0;
      tx_data_val      = 1'b0;
      tx_data          = '0;
      tx_data_last     = 1'b0;
      tx_data_padbytes = '0;
      case (state_reg)
         META: begin
            tx_meta_val = req_meta_val[grant_reg];
            tx_meta     = req_meta[int'(grant_reg)*META_W +: META_W];
         end
         DATA: begin
            tx_data_val      = req_data_val[grant_reg];
            tx_data          = req_data[int'(grant_reg)*DATA_W +: DATA_W];
            tx_data_last     = req_data_last[grant_reg];
            tx_data_padbytes = req_data_padbytes[int'(grant_reg)*PAD_W +: PAD_W];
         end
         WDOG_CLOSE: begin
            tx_data_val  = 1'b1;
            tx_data_last = 1'b1;
         end
         default: ;
      endcase
   end

   // Per-engine ready demux: only the grant holder ever sees a ready.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
      assign req_meta_rdy[gi] = (state_reg == META) && (grant_reg == GRANT_W'(gi)) && tx_meta_rdy;
      assign req_data_rdy[gi] = (state_reg == DATA) && (grant_reg == GRANT_W'(gi)) && tx_data_rdy;
   end

endmodule

// File: tb/tb_vr_udp_tx_arbiter.sv
// Directed testbench for vr_udp_tx_arbiter (watchdog step runs only with VR_TX_ARB_WDOG_EN).
module tb_vr_udp_tx_arbiter;

   localparam int NR = 4;
   localparam int MW = 96;
   localparam int DW = 512;
   localparam int PW = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_meta_val;
   logic [NR*MW-1:0]  req_meta;
   logic [NR-1:0]     req_meta_rdy;
   logic [NR-1:0]     req_data_val;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_data_last;
   logic [NR*PW-1:0]  req_data_padbytes;
   logic [NR-1:0]     req_data_rdy;
   logic              tx_meta_val;
   logic [MW-1:0]     tx_meta;
   logic              tx_meta_rdy;
   logic              tx_data_val;
   logic [DW-1:0]     tx_data;
   logic              tx_data_last;
   logic [PW-1:0]     tx_data_padbytes;
   logic              tx_data_rdy;
   logic [1:0]        grant_id;
   logic              arb_busy;
   logic              wdog_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vr_udp_tx_arbiter #(
      .NUM_REQ (NR), .META_W (MW), .DATA_W (DW), .PAD_W (PW), .WDOG_CYCLES (16)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .req_meta_val (req_meta_val), .req_meta (req_meta), .req_meta_rdy (req_meta_rdy),
      .req_data_val (req_data_val), .req_data (req_data), .req_data_last (req_data_last),
      .req_data_padbytes (req_data_padbytes), .req_data_rdy (req_data_rdy),
      .tx_meta_val (tx_meta_val), .tx_meta (tx_meta), .tx_meta_rdy (tx_meta_rdy),
      .tx_data_val (tx_data_val), .tx_data (tx_data), .tx_data_last (tx_data_last),
      .tx_data_padbytes (tx_data_padbytes), .tx_data_rdy (tx_data_rdy),
      .grant_id (grant_id), .arb_busy (arb_busy), .wdog_err (wdog_err)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MW-1:0] mpat(input int id, input int seq);
      logic [31:0] w;
      w = 32'hB000_0000 + 32'(id * 256 + seq);
      return {3{w}};
   endfunction

   function automatic logic [DW-1:0] dpat(input int id, input int beat, input int seq);
      logic [31:0] w;
      w = 32'hA000_0000 + 32'(id * 65536 + seq * 16 + beat);
      return {16{w}};
   endfunction

   function automatic logic [NR-1:0] onehot(input int id);
      logic [NR-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   task automatic request(input int id, input int seq);
      req_meta_val[id] = 1'b1;
      req_meta[id*MW +: MW] = mpat(id, seq);
   endtask

   task automatic set_beat(input int id, input int beat, input int nbeats, input logic [PW-1:0] pad, input int seq);
      req_data_val[id] = 1'b1;
      req_data[id*DW +: DW] = dpat(id, beat, seq);
      req_data_last[id] = (beat == nbeats - 1);
      req_data_padbytes[id*PW +: PW] = (beat == nbeats - 1) ? pad : '0;
   endtask

   task automatic clear_data(input int id);
      req_data_val[id] = 1'b0;
      req_data_last[id] = 1'b0;
      req_data_padbytes[id*PW +: PW] = '0;
   endtask

   // Serve one message with both tx readies high. Called 1ns after a posedge with the DUT
   // in IDLE and engine id already requesting. Returns 1ns after the last data handshake.
   task automatic serve(input int id, input int nbeats, input logic [PW-1:0] pad, input int seq);
      @(negedge clk);
      chk($sformatf("idle_busy_e%0d", id), 512'(arb_busy), 512'(0));
      chk($sformatf("idle_mrdy_e%0d", id), 512'(req_meta_rdy), 512'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("grant_e%0d", id), 512'(grant_id), 512'(id));
      chk($sformatf("meta_val_e%0d", id), 512'(tx_meta_val), 512'(1));
      chk($sformatf("meta_e%0d", id), 512'(tx_meta), 512'(mpat(id, seq)));
      chk($sformatf("mrdy_e%0d", id), 512'(req_meta_rdy), 512'(onehot(id)));
      chk($sformatf("drdy_meta_e%0d", id), 512'(req_data_rdy), 512'(0));
      @(posedge clk); #1;
      req_meta_val[id] = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         set_beat(id, b, nbeats, pad, seq);
         @(negedge clk);
         chk($sformatf("dval_e%0d_b%0d", id, b), 512'(tx_data_val), 512'(1));
         chk($sformatf("data_e%0d_b%0d", id, b), tx_data, 512'(dpat(id, b, seq)));
         chk($sformatf("last_e%0d_b%0d", id, b), 512'(tx_data_last), 512'(b == nbeats - 1));
         chk($sformatf("pad_e%0d_b%0d", id, b), 512'(tx_data_padbytes),
             512'((b == nbeats - 1) ? pad : 6'd0));
         chk($sformatf("drdy_e%0d_b%0d", id, b), 512'(req_data_rdy), 512'(onehot(id)));
         chk($sformatf("mrdy_d_e%0d_b%0d", id, b), 512'(req_meta_rdy), 512'(0));
         @(posedge clk); #1;
      end
      clear_data(id);
   endtask

   initial begin
      int beat;
      rst_n = 1'b0;
      req_meta_val = '0; req_meta = '0; req_data_val = '0; req_data = '0;
      req_data_last = '0; req_data_padbytes = '0;
      tx_meta_rdy = 1'b1; tx_data_rdy = 1'b1;

      // Reset state
      #12;
      chk("rst_busy", 512'(arb_busy), 512'(0));
      chk("rst_grant", 512'(grant_id), 512'(0));
      chk("rst_wdog", 512'(wdog_err), 512'(0));
      chk("rst_tx_meta_val", 512'(tx_meta_val), 512'(0));
      chk("rst_tx_data_val", 512'(tx_data_val), 512'(0));
      chk("rst_rdys", 512'({req_meta_rdy, req_data_rdy}), 512'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // All four engines request from reset: order 0,1,2,3, one beat each
      for (int i = 0; i < NR; i++) request(i, 10 + i);
      for (int i = 0; i < NR; i++) serve(i, 1, 6'd0, 10 + i);
      $display("step all4: grants 0..3 served, failures=%0d", failures);

      // Single engine 2: meta + 3 beats, padbytes 5
      request(2, 1);
      serve(2, 3, 6'd5, 1);
      $display("step single_e2: 3 beats, failures=%0d", failures);

      // rr_ptr now 3: engines 0 and 3 together -> 3 first
      request(0, 2); request(3, 3);
      serve(3, 1, 6'd1, 3);
      serve(0, 2, 6'd2, 2);
      $display("step rr_after_e2: 3 then 0, failures=%0d", failures);

      // Backpressure on engine 1; engine 0 drives junk data that must be ignored
      request(1, 30);
      tx_meta_rdy = 1'b0;
      req_data_val[0] = 1'b1; req_data[0 +: DW] = '1;
      @(negedge clk);
      chk("bp_idle", 512'(arb_busy), 512'(0));
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp_meta_val_c%0d", c), 512'(tx_meta_val), 512'(1));
         chk($sformatf("bp_mrdy_c%0d", c), 512'({req_meta_rdy, req_data_rdy}), 512'(0));
         chk($sformatf("bp_txdval_c%0d", c), 512'(tx_data_val), 512'(0));
         @(posedge clk); #1;
      end
      tx_meta_rdy = 1'b1;
      @(negedge clk);
      chk("bp_mrdy_release", 512'(req_meta_rdy), 512'(4'b0010));
      @(posedge clk); #1;
      req_meta_val[1] = 1'b0;
      beat = 0;
      set_beat(1, 0, 3, 6'd7, 30);
      for (int c = 0; c < 6; c++) begin
         tx_data_rdy = c[0];
         @(negedge clk);
         chk($sformatf("bp_data_c%0d", c), tx_data, 512'(dpat(1, beat, 30)));
         chk($sformatf("bp_last_c%0d", c), 512'(tx_data_last), 512'(beat == 2));
         chk($sformatf("bp_drdy_c%0d", c), 512'(req_data_rdy), 512'(c[0] ? 4'b0010 : 4'b0000));
         chk($sformatf("bp_mrdy_d_c%0d", c), 512'(req_meta_rdy), 512'(0));
         @(posedge clk); #1;
         if (c[0]) beat++;
         if (beat < 3) set_beat(1, beat, 3, 6'd7, 30);
         else clear_data(1);
      end
      clear_data(0);
      tx_data_rdy = 1'b1;
      @(negedge clk);
      chk("bp_done_idle", 512'(arb_busy), 512'(0));
      @(posedge clk); #1;
      $display("step backpressure: 3 beats through toggling rdy, failures=%0d", failures);

      // rr_ptr = 2 after engine 1: engines 1 and 3 pending -> 3 before 1
      request(1, 40); request(3, 41);
      serve(3, 1, 6'd3, 41);
      serve(1, 1, 6'd4, 40);
      $display("step rr_1_3: 3 then 1, failures=%0d", failures);

      // Reset mid-DATA
      request(0, 50);
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_meta_val[0] = 1'b0;
      set_beat(0, 0, 2, 6'd0, 50);
      @(negedge clk);
      chk("mid_data_val", 512'(tx_data_val), 512'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("arst_data_val", 512'(tx_data_val), 512'(0));
      chk("arst_busy", 512'(arb_busy), 512'(0));
      chk("arst_rdys", 512'({req_meta_rdy, req_data_rdy}), 512'(0));
      chk("arst_data", tx_data, 512'(0));
      clear_data(0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      request(1, 60); request(3, 61);
      serve(1, 1, 6'd0, 60);
      serve(3, 1, 6'd0, 61);
      $display("step reset_mid_data: rr_ptr restarted at 0, failures=%0d", failures);

`ifdef VR_TX_ARB_WDOG_EN
      // Engine 0 stalls after one beat; engine 1 waits
      request(0, 70); request(1, 71);
      @(negedge clk);
      chk("wd_idle", 512'(arb_busy), 512'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_grant0", 512'(grant_id), 512'(0));
      @(posedge clk); #1;
      req_meta_val[0] = 1'b0;
      set_beat(0, 0, 4, 6'd0, 70);
      @(negedge clk);
      chk("wd_beat0", tx_data, 512'(dpat(0, 0, 70)));
      @(posedge clk); #1;
      clear_data(0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("wd_stall_val_%0d", i), 512'(tx_data_val), 512'(0));
         chk($sformatf("wd_stall_busy_%0d", i), 512'(arb_busy), 512'(1));
         @(posedge clk); #1;
      end
      tx_data_rdy = 1'b0;
      @(negedge clk);
      chk("wd_close_val", 512'(tx_data_val), 512'(1));
      chk("wd_close_last", 512'(tx_data_last), 512'(1));
      chk("wd_close_pad", 512'(tx_data_padbytes), 512'(0));
      chk("wd_err_before", 512'(wdog_err), 512'(0));
      chk("wd_close_drdy", 512'(req_data_rdy), 512'(0));
      @(posedge clk); #1;
      tx_data_rdy = 1'b1;
      @(negedge clk);
      chk("wd_close_hold", 512'({tx_data_val, tx_data_last}), 512'(2'b11));
      @(posedge clk); #1;
      serve(1, 1, 6'd0, 71);
      chk("wd_err_sticky", 512'(wdog_err), 512'(1));
      $display("step watchdog: close beat sent, engine 1 granted next, failures=%0d", failures);
`else
      chk("wdog_err_tied", 512'(wdog_err), 512'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
